// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants for the fetch-stage PC unit: chip-enable levels,
// reset polarity, default address width and PC state encodings.
package pc_fetch_ctrl_pkg;

    localparam int InstAddrBus = 32;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic RstActiveLow = 1'b0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

endpackage

// File: rtl/pc_fetch_ctrl_redirect_buf.sv
// One-entry redirect target buffer with a valid bit.
// Priority per edge: reset, flush-clear, set/overwrite, clear.
module pc_redirect_buf
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              set,
    input  logic              clr,
    input  logic [ADDR_W-1:0] target_in,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    // Hold the newest redirect that could not be applied yet; flush discards it
    always_ff @(posedge clk) begin
        if (rst == RstActiveLow) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (set) begin
            valid  <= 1'b1;
            target <= target_in;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: drives instruction-memory enable and fetch
// address, advancing only when memory accepts and the PC stage is not stalled.
// Redirects that arrive while the PC cannot advance are parked in a
// one-entry buffer and applied on the next advance.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                INC       = 4,
    parameter int                STALL_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               inst_ack,
    output logic               ce,
    output logic [ADDR_W-1:0]  pc,
    output logic               redirect_pending
);

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    logic [0:0]        state;
    logic              run;
    logic              adv;
    logic              buf_set;
    logic              buf_clr;
    logic              buf_flush;
    logic [ADDR_W-1:0] buf_target;
    logic              stall_unused;

    // Only the PC-stage bit of the stall vector matters here
    assign stall_unused = ^stall;

    assign run = (state == S_RUN);
    assign adv = inst_ack & ~stall[0];

    // Buffer a branch when it cannot be taken now, or when an older buffered
    // redirect is being consumed this edge; consume the buffer on advance.
    assign buf_flush = run & flush;
    assign buf_set   = run & branch_flag & (~adv | redirect_pending);
    assign buf_clr   = run & adv & redirect_pending;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (buf_flush),
        .set       (buf_set),
        .clr       (buf_clr),
        .target_in (branch_target),
        .valid     (redirect_pending),
        .target    (buf_target)
    );

    // State, chip enable and PC update with flush > buffered > branch > sequential
    always_ff @(posedge clk) begin
        if (rst == RstActiveLow) begin
            state <= S_IDLE;
            ce    <= ChipDisable;
            pc    <= RESET_VEC;
        end else if (state == S_IDLE) begin
            state <= S_RUN;
            ce    <= ChipEnable;
            pc    <= RESET_VEC;
        end else begin
            ce <= ChipEnable;
            if (flush) begin
                pc <= new_pc;
            end else if (adv && redirect_pending) begin
                pc <= buf_target;
            end else if (adv && branch_flag) begin
                pc <= branch_target;
            end else if (adv) begin
                pc <= pc + INC_V;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a default 32-bit instance and a
// 16-bit instance with INC=2 and a non-zero reset vector.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_ack;
    logic        ce;
    logic [31:0] pc;
    logic        redirect_pending;

    logic        rst2;
    logic        flush2;
    logic [15:0] new_pc2;
    logic        ack2;
    logic        ce2;
    logic [15:0] pc2;
    logic        pend2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .branch_flag      (branch_flag),
        .branch_target    (branch_target),
        .inst_ack         (inst_ack),
        .ce               (ce),
        .pc               (pc),
        .redirect_pending (redirect_pending)
    );

    pc_fetch_ctrl #(
        .ADDR_W    (16),
        .RESET_VEC (16'h0400),
        .INC       (2),
        .STALL_W   (6)
    ) dut16 (
        .clk              (clk),
        .rst              (rst2),
        .stall            (6'b0),
        .flush            (flush2),
        .new_pc           (new_pc2),
        .branch_flag      (1'b0),
        .branch_target    (16'h0000),
        .inst_ack         (ack2),
        .ce               (ce2),
        .pc               (pc2),
        .redirect_pending (pend2)
    );

    // Advance one edge; outputs are read 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; inst_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (ce !== 1'b0 || pc !== 32'h0 || redirect_pending !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: ce=%b pc=%h pend=%b, want ce=0 pc=0 pend=0", i, ce, pc, redirect_pending);
            end
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (ce !== 1'b1 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL first_fetch: ce=%b pc=%h, want ce=1 pc=0", ce, pc);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (pc !== 32'(4 * i)) begin
                n_bad++;
                $display("FAIL seq_inc[%0d]: pc=%h want %h", i, pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_wait_states();
        step();
        n_cmp++;
        if (pc !== 32'h10) begin
            n_bad++;
            $display("FAIL wait_setup: pc=%h want 10", pc);
        end
        inst_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (pc !== 32'h10) begin
                n_bad++;
                $display("FAIL wait_hold[%0d]: pc=%h want 10", i, pc);
            end
        end
        inst_ack = 1'b1;
        step();
        n_cmp++;
        if (pc !== 32'h14) begin
            n_bad++;
            $display("FAIL wait_release: pc=%h want 14", pc);
        end
    endtask

    task automatic test_stall();
        stall = 6'b000001;
        step();
        n_cmp++;
        if (pc !== 32'h14) begin
            n_bad++;
            $display("FAIL stall0_hold: pc=%h want 14", pc);
        end
        stall = 6'b111110;
        step();
        n_cmp++;
        if (pc !== 32'h18) begin
            n_bad++;
            $display("FAIL stall_upper_ignored: pc=%h want 18", pc);
        end
        stall = 6'b0;
    endtask

    task automatic test_branch_during_wait();
        flush = 1'b1; new_pc = 32'h20;
        step();
        flush = 1'b0;
        n_cmp++;
        if (pc !== 32'h20) begin
            n_bad++;
            $display("FAIL flush_to_20: pc=%h want 20", pc);
        end
        inst_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
        step();
        branch_flag = 1'b0;
        n_cmp++;
        if (pc !== 32'h20 || redirect_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_buffered: pc=%h pend=%b, want pc=20 pend=1", pc, redirect_pending);
        end
        step();
        n_cmp++;
        if (pc !== 32'h20 || redirect_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_still_pending: pc=%h pend=%b, want pc=20 pend=1", pc, redirect_pending);
        end
        inst_ack = 1'b1;
        step();
        n_cmp++;
        if (pc !== 32'h100 || redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_applied: pc=%h pend=%b, want pc=100 pend=0", pc, redirect_pending);
        end
        step();
        n_cmp++;
        if (pc !== 32'h104) begin
            n_bad++;
            $display("FAIL after_branch: pc=%h want 104", pc);
        end
        branch_flag = 1'b1; branch_target = 32'h2A2;
        step();
        branch_flag = 1'b0;
        n_cmp++;
        if (pc !== 32'h2A2 || redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_branch_unaligned: pc=%h pend=%b, want pc=2a2 pend=0", pc, redirect_pending);
        end
    endtask

    task automatic test_back_to_back();
        inst_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h300;
        step();
        branch_target = 32'h340;
        step();
        inst_ack = 1'b1; branch_target = 32'h500;
        step();
        branch_flag = 1'b0;
        n_cmp++;
        if (pc !== 32'h340 || redirect_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL newest_wins_and_rebuffer: pc=%h pend=%b, want pc=340 pend=1", pc, redirect_pending);
        end
        step();
        n_cmp++;
        if (pc !== 32'h500 || redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL rebuffered_applied: pc=%h pend=%b, want pc=500 pend=0", pc, redirect_pending);
        end
    endtask

    task automatic test_flush_priority();
        stall = 6'b000001; inst_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h200;
        step();
        branch_flag = 1'b0;
        n_cmp++;
        if (redirect_pending !== 1'b1 || pc !== 32'h500) begin
            n_bad++;
            $display("FAIL flush_setup: pc=%h pend=%b, want pc=500 pend=1", pc, redirect_pending);
        end
        flush = 1'b1; new_pc = 32'h180;
        step();
        flush = 1'b0;
        n_cmp++;
        if (pc !== 32'h180 || redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_wins: pc=%h pend=%b, want pc=180 pend=0", pc, redirect_pending);
        end
        stall = 6'b0; inst_ack = 1'b1;
        step();
        n_cmp++;
        if (pc !== 32'h184) begin
            n_bad++;
            $display("FAIL flush_discards_buf: pc=%h want 184", pc);
        end
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; new_pc = 32'h3C;
        step();
        flush = 1'b0; inst_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h700;
        step();
        branch_flag = 1'b0;
        n_cmp++;
        if (pc !== 32'h3C || redirect_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup: pc=%h pend=%b, want pc=3c pend=1", pc, redirect_pending);
        end
        rst = 1'b0; inst_ack = 1'b1;
        step();
        n_cmp++;
        if (ce !== 1'b0 || pc !== 32'h0 || redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: ce=%b pc=%h pend=%b, want ce=0 pc=0 pend=0", ce, pc, redirect_pending);
        end
        // Idle ignores flush and branch on the release edge
        rst = 1'b1; flush = 1'b1; new_pc = 32'h999; branch_flag = 1'b1; branch_target = 32'h888;
        step();
        flush = 1'b0; branch_flag = 1'b0;
        n_cmp++;
        if (ce !== 1'b1 || pc !== 32'h0 || redirect_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ignores: ce=%b pc=%h pend=%b, want ce=1 pc=0 pend=0", ce, pc, redirect_pending);
        end
        step();
        n_cmp++;
        if (pc !== 32'h4) begin
            n_bad++;
            $display("FAIL refetch: pc=%h want 4", pc);
        end
    endtask

    task automatic test_wrap16();
        rst2 = 1'b0; ack2 = 1'b1;
        step();
        step();
        n_cmp++;
        if (ce2 !== 1'b0 || pc2 !== 16'h0400 || pend2 !== 1'b0) begin
            n_bad++;
            $display("FAIL w16_reset: ce=%b pc=%h pend=%b, want ce=0 pc=0400 pend=0", ce2, pc2, pend2);
        end
        rst2 = 1'b1;
        step();
        n_cmp++;
        if (ce2 !== 1'b1 || pc2 !== 16'h0400) begin
            n_bad++;
            $display("FAIL w16_first: ce=%b pc=%h, want ce=1 pc=0400", ce2, pc2);
        end
        step();
        n_cmp++;
        if (pc2 !== 16'h0402) begin
            n_bad++;
            $display("FAIL w16_inc2: pc=%h want 0402", pc2);
        end
        flush2 = 1'b1; new_pc2 = 16'hFFFE;
        step();
        flush2 = 1'b0;
        n_cmp++;
        if (pc2 !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL w16_flush: pc=%h want fffe", pc2);
        end
        step();
        n_cmp++;
        if (pc2 !== 16'h0000) begin
            n_bad++;
            $display("FAIL w16_wrap: pc=%h want 0000", pc2);
        end
    endtask

    initial begin
        rst = 1'b0; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
        branch_flag = 1'b0; branch_target = 32'h0; inst_ack = 1'b0;
        rst2 = 1'b0; flush2 = 1'b0; new_pc2 = 16'h0; ack2 = 1'b0;
        test_reset();
        test_wait_states();
        test_stall();
        test_branch_during_wait();
        test_back_to_back();
        test_flush_priority();
        test_reset_mid();
        test_wrap16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
